// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage data-memory access sequencer. Latches the EX/MEM
//               address/data, runs a req/ack handshake with a variable-latency
//               memory, stalls the upstream pipeline until completion, aborts
//               to a sticky error on a watchdog timeout and counts stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int TIMEOUT = 64,   // REQ cycles without ack before abort (1..255)
    parameter int CNT_W   = 16    // width of the saturating stall counter
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             stall_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [1:0] c_ERR  = 2'd3;

    // Counter value seen on the last permitted REQ cycle.
    localparam logic [7:0]       c_TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [7:0] r_tmo_cnt;
    logic       w_access;
    logic       w_ack_hit;
    logic       w_tmo_hit;

    assign w_access  = MemRead_i | MemWrite_i;
    assign w_ack_hit = (r_state == c_REQ) & mem_ack_i;
    // An ack on the final permitted cycle takes priority over the abort.
    assign w_tmo_hit = (r_state == c_REQ) & ~mem_ack_i & (r_tmo_cnt == c_TMO_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; acks outside REQ are ignored by construction.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_access) begin
                    w_next_state = c_REQ;
                end
            end
            c_REQ: begin
                if (mem_ack_i) begin
                    w_next_state = c_DONE;
                end else if (w_tmo_hit) begin
                    w_next_state = c_ERR;
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            c_ERR:   w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Outputs decoded from state; stall is forced low while reset is held so
    // the pipeline is released immediately on an asynchronous reset.
    always_comb begin
        mem_req_o = (r_state == c_REQ);
        stall_o   = rst_i & w_access & ((r_state == c_IDLE) | (r_state == c_REQ));
    end

    // Request attributes latched on acceptance, load data and sticky error.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_we_o    <= 1'b0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) && w_access) begin
                mem_addr_o  <= addr_i;
                mem_wdata_o <= wdata_i;
                mem_we_o    <= MemWrite_i;   // write wins when both bits are set
            end
            if (w_ack_hit && !mem_we_o) begin
                rdata_o <= mem_rdata_i;
            end else if (w_tmo_hit) begin
                rdata_o <= '0;
            end
            if (w_tmo_hit) begin
                err_o <= 1'b1;
            end
        end
    end

    // Watchdog: counts cycles spent in REQ, cleared everywhere else.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_tmo_cnt <= '0;
        end else if (r_state == c_REQ) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != c_CNT_MAX)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the 5-stage pipeline.
- Decodes the registered MEM control bits (MemRead/MemWrite) and address/data from the EX/MEM pipeline register.
- Issues a request/acknowledge transaction to a variable-latency data memory.
- Drives a stall that freezes PC, IF/ID, ID/EX and EX/MEM until the access completes; watchdog flags a memory that never acknowledges.

Parameters:
- TIMEOUT, 64: maximum cycles spent in REQ without mem_ack_i before aborting to ERR; legal range 1..255.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- MemRead_i  input  1  load in MEM stage (EX/MEM M bit).
- MemWrite_i  input  1  store in MEM stage (EX/MEM M bit).
- addr_i  input  32  ALU result from EX/MEM (byte address).
- wdata_i  input  32  store data from EX/MEM.
- mem_req_o  output  1  request to data memory, held until ack.
- mem_we_o  output  1  1 = write, 0 = read; valid while mem_req_o.
- mem_addr_o  output  32  latched address.
- mem_wdata_o  output  32  latched store data.
- mem_ack_i  input  1  memory completion, single-cycle pulse.
- mem_rdata_i  input  32  read data, valid when mem_ack_i.
- stall_o  output  1  freeze upstream pipeline registers and PC.
- rdata_o  output  32  load result to MEM/WB.
- err_o  output  1  sticky timeout flag.
- stall_cnt_o  output  CNT_W  total cycles stall_o was high, saturating.

Behaviour:
- access = MemRead_i | MemWrite_i.
- Reset (async, rst_i=0):
  - state = IDLE.
  - mem_req_o, mem_we_o, err_o = 0.
  - mem_addr_o, mem_wdata_o, rdata_o, stall_cnt_o = 0.
  - Timeout counter = 0.
  - Outputs change immediately, without waiting for a clock edge, including mid-transaction.
- States: IDLE, REQ, DONE, ERR (registered).
- IDLE:
  - If access: latch addr_i into mem_addr_o and wdata_i into mem_wdata_o; set mem_we_o = MemWrite_i; set mem_req_o = 1; go to REQ.
  - If MemRead_i and MemWrite_i are both 1, the write wins (mem_we_o = 1).
  - mem_ack_i is ignored in IDLE.
- REQ:
  - mem_req_o held at 1; address, data and we held stable.
  - Timeout counter increments each cycle in REQ.
  - If mem_ack_i: clear mem_req_o. If the access is a read, capture mem_rdata_i into rdata_o (rdata_o is unchanged for writes). Go to DONE.
  - Else if the counter reaches TIMEOUT: clear mem_req_o, set err_o = 1, rdata_o = 0, go to ERR.
  - An ack on the TIMEOUT-th cycle wins over the timeout.
- DONE: single cycle, stall_o = 0 so the pipeline advances on this edge; go to IDLE; counter cleared.
- ERR: identical to DONE (stall released, go to IDLE), but err_o stays 1 until reset.
- stall_o (combinational) = access & (state == IDLE or state == REQ).
  - Low in DONE/ERR, so a held instruction is never re-issued.
  - The next instruction is evaluated in IDLE the cycle after DONE.
- Minimum occupancy: access in cycle 0 (IDLE), req in cycle 1, ack in cycle 1, DONE in cycle 2. stall_o is high in cycles 0–1, rdata_o is valid from cycle 2.
- Each extra wait cycle adds one stall cycle.
- Non-memory instructions: stall_o = 0, no request, zero added latency.
- mem_ack_i outside REQ is ignored; rdata_o holds its last value.
- stall_cnt_o increments on every edge where stall_o = 1 and saturates at all-ones.
- Input changes while in REQ are ignored (values are latched).

Test Plan:
- Read, ack in first REQ cycle:
  - Stimulus: MemRead_i=1, addr_i=0x0000_0010, mem_rdata_i=0xDEAD_BEEF.
  - Required: mem_req_o high exactly 1 cycle, mem_we_o=0, mem_addr_o=0x10, stall_o high 2 cycles, rdata_o=0xDEADBEEF in DONE, stall_cnt_o=2.
- Write with 3 wait cycles:
  - Stimulus: MemWrite_i=1, addr_i=0x20, wdata_i=0x1234_5678, ack on 4th REQ cycle.
  - Required: mem_we_o=1, address/data stable 4 cycles, stall_o high 5 cycles, rdata_o unchanged.
- Back-to-back load then store:
  - Required: exactly one request each, separated by the DONE+IDLE cycles, no duplicate request for the first instruction.
- Timeout with TIMEOUT=4, no ack:
  - Required: REQ for 4 cycles, then ERR with err_o=1, rdata_o=0, stall released; err_o stays 1 through later successful accesses.
- Reset mid-REQ:
  - Stimulus: rst_i=0 asynchronously during a wait.
  - Required: mem_req_o, stall_o, stall_cnt_o drop to 0 immediately; after release, a new MemRead_i access completes normally.
- Both MemRead_i and MemWrite_i set, plus a stray ack in IDLE:
  - Required: mem_we_o=1; the stray ack causes no state change.
